// File: rtl/qbus_pkg.sv
// Shared definitions for QBUS target-side logic: FSM states, active-low bus level, timeout width.
package qbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RDREQ,
        S_RDDRV,
        S_RDRPLY,
        S_WRREQ,
        S_WRRPLY,
        S_WAITSYNC
    } state_t;

    localparam logic BUS_ACT = 1'b0;
    localparam int   TMO_W   = 6;

endpackage

// File: rtl/qbus_addr_match.sv
// Combinational address-window compare shared by every target on the bus.
// The window is 2**ADDR_W bytes; the low ADDR_W address bits do not take part in the compare.
module qbus_addr_match #(
    parameter logic [15:0] BASE_ADDR = 16'o176500,
    parameter int          ADDR_W    = 3
) (
    input  logic [15:0] addr_i,
    output logic        hit_o
);
    localparam logic [15:0] WIN_MASK = ~((16'd1 << ADDR_W) - 16'd1);

    assign hit_o = ((addr_i ^ BASE_ADDR) & WIN_MASK) == 16'd0;

endmodule

// File: rtl/qbus_target.sv
// QBUS slave: decodes a word window, turns DIN/DOUT cycles into a local rd/wr + ack handshake.
// RPLY is registered: read RPLY at loc_ack+2, write RPLY at loc_ack+1.
module qbus_target
    import qbus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'o176500,
    parameter int          ADDR_W      = 3,
    parameter int          LOC_TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              sync,
    input  logic              din,
    input  logic              dout,
    input  logic              wtbt,
    input  logic              iako,
    output logic              rply,
    inout  wire  [15:0]       ad,
    output logic [ADDR_W-2:0] loc_addr,
    output logic              loc_rd,
    output logic              loc_wr,
    output logic [1:0]        loc_be,
    output logic [15:0]       loc_wdata,
    input  logic [15:0]       loc_rdata,
    input  logic              loc_ack
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOC_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [15:0]        addr_sh_q;
    logic               sync_prev_q;
    logic               rply_q, rply_d;
    logic               loc_rd_q, loc_rd_d;
    logic               loc_wr_q, loc_wr_d;
    logic [1:0]         loc_be_q, loc_be_d;
    logic [ADDR_W-2:0]  loc_addr_q, loc_addr_d;
    logic [15:0]        loc_wdata_q, loc_wdata_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               a_lsb_q, a_lsb_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               hit;
    logic               ad_oe;

    qbus_addr_match #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W)
    ) u_match (
        .addr_i (addr_sh_q),
        .hit_o  (hit)
    );

    // The address leaves AD as soon as SYNC asserts, so keep the last value seen with SYNC high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_sh_q   <= 16'd0;
            sync_prev_q <= 1'b1;
        end else begin
            if (sync != BUS_ACT) begin
                addr_sh_q <= ad;
            end
            sync_prev_q <= sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rply_q      <= 1'b1;
            loc_rd_q    <= 1'b0;
            loc_wr_q    <= 1'b0;
            loc_be_q    <= 2'b00;
            loc_addr_q  <= '0;
            loc_wdata_q <= 16'd0;
            rdata_q     <= 16'd0;
            a_lsb_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rply_q      <= rply_d;
            loc_rd_q    <= loc_rd_d;
            loc_wr_q    <= loc_wr_d;
            loc_be_q    <= loc_be_d;
            loc_addr_q  <= loc_addr_d;
            loc_wdata_q <= loc_wdata_d;
            rdata_q     <= rdata_d;
            a_lsb_q     <= a_lsb_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rply_d      = 1'b1;
        loc_rd_d    = loc_rd_q;
        loc_wr_d    = loc_wr_q;
        loc_be_d    = loc_be_q;
        loc_addr_d  = loc_addr_q;
        loc_wdata_d = loc_wdata_q;
        rdata_d     = rdata_q;
        a_lsb_d     = a_lsb_q;
        cnt_d       = cnt_q;

        // SYNC negated outside IDLE means the master gave up (or finished): release everything.
        if (state_q != S_IDLE && sync != BUS_ACT) begin
            state_d  = S_IDLE;
            loc_rd_d = 1'b0;
            loc_wr_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (sync == BUS_ACT && sync_prev_q != BUS_ACT) begin
                        if (hit) begin
                            state_d    = S_ADDR;
                            loc_addr_d = addr_sh_q[ADDR_W-1:1];
                            a_lsb_d    = addr_sh_q[0];
                        end else begin
                            state_d = S_WAITSYNC;
                        end
                    end
                end
                S_ADDR: begin
                    if (din == BUS_ACT) begin
                        if (iako != BUS_ACT) begin
                            state_d  = S_RDREQ;
                            loc_rd_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            state_d = S_WAITSYNC;
                        end
                    end else if (dout == BUS_ACT) begin
                        state_d     = S_WRREQ;
                        loc_wr_d    = 1'b1;
                        loc_wdata_d = ad;
                        loc_be_d    = (wtbt != BUS_ACT) ? 2'b11 : (a_lsb_q ? 2'b10 : 2'b01);
                        cnt_d       = '0;
                    end
                end
                S_RDREQ: begin
                    cnt_d = cnt_q + 1'b1;
                    if (loc_ack) begin
                        state_d  = S_RDDRV;
                        rdata_d  = loc_rdata;
                        loc_rd_d = 1'b0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d  = S_WAITSYNC;
                        loc_rd_d = 1'b0;
                    end
                end
                S_RDDRV: begin
                    state_d = S_RDRPLY;
                    rply_d  = 1'b0;
                end
                S_RDRPLY: begin
                    if (din != BUS_ACT) begin
                        state_d = S_WAITSYNC;
                    end else begin
                        rply_d = 1'b0;
                    end
                end
                S_WRREQ: begin
                    cnt_d = cnt_q + 1'b1;
                    if (loc_ack) begin
                        state_d  = S_WRRPLY;
                        loc_wr_d = 1'b0;
                        rply_d   = 1'b0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d  = S_WAITSYNC;
                        loc_wr_d = 1'b0;
                    end
                end
                S_WRRPLY: begin
                    if (dout != BUS_ACT) begin
                        state_d = S_WAITSYNC;
                    end else begin
                        rply_d = 1'b0;
                    end
                end
                S_WAITSYNC: begin
                    state_d = S_WAITSYNC;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (init == BUS_ACT) begin
            state_d     = S_IDLE;
            rply_d      = 1'b1;
            loc_rd_d    = 1'b0;
            loc_wr_d    = 1'b0;
            loc_be_d    = 2'b00;
            loc_addr_d  = '0;
            loc_wdata_d = 16'd0;
            rdata_d     = 16'd0;
            a_lsb_d     = 1'b0;
            cnt_d       = '0;
        end
    end

    assign ad_oe     = (state_q == S_RDDRV) || (state_q == S_RDRPLY);
    assign ad        = ad_oe ? rdata_q : 16'hzzzz;
    assign rply      = rply_q;
    assign loc_rd    = loc_rd_q;
    assign loc_wr    = loc_wr_q;
    assign loc_be    = loc_be_q;
    assign loc_addr  = loc_addr_q;
    assign loc_wdata = loc_wdata_q;

endmodule

// File: tb/tb_qbus_target.sv
// Directed bench for qbus_target: read/write hits, miss, IAKO, timeout, abort, reset and INIT.
module tb_qbus_target;
    import qbus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b1;
    logic        sync = 1'b1;
    logic        din = 1'b1;
    logic        dout = 1'b1;
    logic        wtbt = 1'b1;
    logic        iako = 1'b1;
    logic        rply;
    tri1  [15:0] ad;
    logic [15:0] tb_ad = 16'd0;
    logic        tb_oe = 1'b0;
    logic [1:0]  loc_addr;
    logic        loc_rd;
    logic        loc_wr;
    logic [1:0]  loc_be;
    logic [15:0] loc_wdata;
    logic [15:0] loc_rdata = 16'd0;
    logic        loc_ack = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    assign ad = tb_oe ? tb_ad : 16'hzzzz;

    always #5 clk = ~clk;

    qbus_target #(
        .BASE_ADDR   (16'o176500),
        .ADDR_W      (3),
        .LOC_TIMEOUT (63)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .sync      (sync),
        .din       (din),
        .dout      (dout),
        .wtbt      (wtbt),
        .iako      (iako),
        .rply      (rply),
        .ad        (ad),
        .loc_addr  (loc_addr),
        .loc_rd    (loc_rd),
        .loc_wr    (loc_wr),
        .loc_be    (loc_be),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .loc_ack   (loc_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [15:0] a);
        sync  = 1'b1;
        tb_oe = 1'b1;
        tb_ad = a;
        tick();
        sync  = 1'b0;
        tb_oe = 1'b0;
    endtask

    task automatic bus_idle();
        sync  = 1'b1;
        din   = 1'b1;
        dout  = 1'b1;
        wtbt  = 1'b1;
        iako  = 1'b1;
        tb_oe = 1'b0;
        loc_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int  n;
        logic rply_seen;

        tick();
        tick();
        check("rst_rply",  32'(rply),      32'h1);
        check("rst_ad",    32'(ad),        32'hFFFF);
        check("rst_rd",    32'(loc_rd),    32'h0);
        check("rst_wr",    32'(loc_wr),    32'h0);
        check("rst_be",    32'(loc_be),    32'h0);
        check("rst_addr",  32'(loc_addr),  32'h0);
        check("rst_wdata", 32'(loc_wdata), 32'h0);
        reset = 1'b0;
        tick();

        // Read hit, ack three cycles after the request.
        addr_phase(16'o176502);
        din = 1'b0;
        tick();
        tick();
        check("rd_req",   32'(loc_rd),   32'h1);
        check("rd_addr",  32'(loc_addr), 32'h1);
        tick();
        tick();
        loc_ack   = 1'b1;
        loc_rdata = 16'hA5C3;
        tick();
        loc_ack   = 1'b0;
        loc_rdata = 16'h0000;
        check("rd_drv_ad",   32'(ad),     32'hA5C3);
        check("rd_drv_rply", 32'(rply),   32'h1);
        check("rd_drop",     32'(loc_rd), 32'h0);
        tick();
        check("rd_rply",    32'(rply), 32'h0);
        check("rd_rply_ad", 32'(ad),   32'hA5C3);
        din = 1'b1;
        tick();
        check("rd_rel_rply", 32'(rply), 32'h1);
        check("rd_rel_ad",   32'(ad),   32'hFFFF);
        bus_idle();

        // Odd byte write.
        addr_phase(16'o176505);
        tb_oe = 1'b1;
        tb_ad = 16'h3400;
        dout  = 1'b0;
        wtbt  = 1'b0;
        tick();
        tick();
        check("wr_req",   32'(loc_wr),    32'h1);
        check("wr_be",    32'(loc_be),    32'h2);
        check("wr_wdata", 32'(loc_wdata), 32'h3400);
        check("wr_addr",  32'(loc_addr),  32'h2);
        check("wr_norply", 32'(rply),     32'h1);
        loc_ack = 1'b1;
        tick();
        loc_ack = 1'b0;
        check("wr_rply", 32'(rply),   32'h0);
        check("wr_drop", 32'(loc_wr), 32'h0);
        dout = 1'b1;
        tick();
        check("wr_rel_rply", 32'(rply), 32'h1);
        bus_idle();

        // Miss: just past the window.
        addr_phase(16'o176510);
        din = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("miss_rd",   32'(loc_rd), 32'h0);
            check("miss_rply", 32'(rply),   32'h1);
            check("miss_ad",   32'(ad),     32'hFFFF);
        end
        bus_idle();

        // Interrupt acknowledge DIN inside the window is not ours.
        addr_phase(16'o176500);
        din  = 1'b0;
        iako = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("iako_rd",   32'(loc_rd), 32'h0);
            check("iako_rply", 32'(rply),   32'h1);
        end
        bus_idle();

        // Timeout: no ack ever arrives.
        addr_phase(16'o176506);
        din = 1'b0;
        tick();
        tick();
        n = 0;
        rply_seen = 1'b0;
        while (loc_rd === 1'b1 && n < 200) begin
            n++;
            if (rply !== 1'b1) rply_seen = 1'b1;
            tick();
        end
        check("tmo_len", 32'(n), 32'd63);
        for (int i = 0; i < 4; i++) begin
            if (rply !== 1'b1) rply_seen = 1'b1;
            tick();
        end
        check("tmo_norply", 32'(rply_seen), 32'h0);
        check("tmo_rd_off", 32'(loc_rd),    32'h0);
        bus_idle();
        check("tmo_idle", 32'(u_dut.state_q), 32'(S_IDLE));

        // Master abort during the RPLY phase of a read.
        addr_phase(16'o176500);
        din = 1'b0;
        tick();
        tick();
        loc_ack   = 1'b1;
        loc_rdata = 16'h1234;
        tick();
        loc_ack = 1'b0;
        tick();
        check("abt_rply0", 32'(rply), 32'h0);
        check("abt_ad0",   32'(ad),   32'h1234);
        sync = 1'b1;
        tick();
        check("abt_rply", 32'(rply), 32'h1);
        check("abt_ad",   32'(ad),   32'hFFFF);
        check("abt_idle", 32'(u_dut.state_q), 32'(S_IDLE));
        bus_idle();

        // Asynchronous reset in the middle of a word write.
        addr_phase(16'o176504);
        tb_oe = 1'b1;
        tb_ad = 16'hBEEF;
        dout  = 1'b0;
        tick();
        tick();
        check("arst_pre_wr", 32'(loc_wr), 32'h1);
        check("arst_pre_be", 32'(loc_be), 32'h3);
        #2 reset = 1'b1;
        #1;
        check("arst_wr",    32'(loc_wr),    32'h0);
        check("arst_be",    32'(loc_be),    32'h0);
        check("arst_addr",  32'(loc_addr),  32'h0);
        check("arst_wdata", 32'(loc_wdata), 32'h0);
        check("arst_rply",  32'(rply),      32'h1);
        bus_idle();
        reset = 1'b0;
        tick();

        // Bus INIT during a write request aborts synchronously.
        addr_phase(16'o176502);
        tb_oe = 1'b1;
        tb_ad = 16'h00FF;
        dout  = 1'b0;
        tick();
        tick();
        check("init_pre_wr", 32'(loc_wr), 32'h1);
        init = 1'b0;
        tick();
        check("init_wr",    32'(loc_wr),    32'h0);
        check("init_wdata", 32'(loc_wdata), 32'h0);
        init = 1'b1;
        bus_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
